// File: rtl/timer_arbiter.sv
// timer_arbiter: two-master arbiter for the timer register port; define ARB_RR_EN for round-robin, else fixed m0 priority
module timer_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [1:0]    m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [1:0]    m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [1:0]    t_addr,
  output logic          t_wr_en,
  output logic [DW-1:0] t_wdata,
  input  logic [DW-1:0] t_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic owner, last_owner, we_q, err_q, win, any_req, undef_addr;
  logic [1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
  assign any_req = m0_req | m1_req;
  assign undef_addr = addr_q == 2'b11;
  // win selects master 1; only consulted when some request is present
`ifdef ARB_RR_EN
  assign win = (m0_req & m1_req) ? ~last_owner : m1_req;
`else
  assign win = ~m0_req;
`endif
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner   <= win;
        addr_q  <= win ? m1_addr : m0_addr;
        we_q    <= win ? m1_we : m0_we;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) begin
        err_q <= undef_addr;
        if (owner) rdata1_q <= t_rdata;
        else rdata0_q <= t_rdata;
      end
      if (state == DONE) last_owner <= owner;
    end
  end
  assign t_addr   = addr_q;
  assign t_wdata  = wdata_q;
  assign t_wr_en  = state == ACCESS && we_q && !undef_addr;
  assign m0_gnt   = state == ACCESS && !owner;
  assign m1_gnt   = state == ACCESS && owner;
  assign m0_done  = state == DONE && !owner;
  assign m1_done  = state == DONE && owner;
  assign m0_err   = m0_done & err_q;
  assign m1_err   = m1_done & err_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
endmodule
